// File: rtl/periph_bus_copy_engine.sv
// periph_bus_copy_engine
//   Bus initiator that copies a block of words from SrcAddr to DstAddr, or
//   fills a destination block with FillValue. It talks to the word-addressed,
//   fixed-latency RAM/GPIO bus. Arbitration happens upstream of this block.
//
// Ports
//   CoreClock       system clock (rising edge)
//   Reset           synchronous, active-high
//   Start           command strobe, only sampled while idle
//   FillMode        0 = copy, 1 = fill with FillValue
//   SrcAddr/DstAddr first source / destination word address
//   WordCount       words to transfer, 0..2^ADDR_W
//   FillValue       fill constant
//   Busy/Done       command in flight / one-cycle completion pulse
//   BusAddress      bus word address
//   BusWriteData    bus write data
//   BusWriteAssert  bus write enable
//   BusReadData     read data, valid READ_LATENCY cycles after its address
module periph_bus_copy_engine #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              CoreClock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              FillMode,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [ADDR_W:0]   WordCount,
  input  logic [DATA_W-1:0] FillValue,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] BusAddress,
  output logic [DATA_W-1:0] BusWriteData,
  output logic              BusWriteAssert,
  input  logic [DATA_W-1:0] BusReadData
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0]      WAIT_LOAD = 2'(READ_LATENCY - 1);
  localparam logic [ADDR_W:0] REM_ONE   = (ADDR_W+1)'(1);

  state_t            state, nextState;
  logic [ADDR_W-1:0] srcPtr, srcNext;
  logic [ADDR_W-1:0] dstPtr, dstNext;
  logic [ADDR_W:0]   remaining, remNext;
  logic [1:0]        waitCnt, waitNext;
  logic              fillMode, fillNext;
  logic [DATA_W-1:0] dataReg, dataNext;
  logic [ADDR_W-1:0] addrReg;
  logic              busyReg, doneReg, writeReg;

  // Next-state and datapath. Outputs are registered from the next-state
  // values, so each output register reflects the state it is entering.
  always_comb begin
    nextState = state;
    srcNext   = srcPtr;
    dstNext   = dstPtr;
    remNext   = remaining;
    waitNext  = waitCnt;
    fillNext  = fillMode;
    dataNext  = dataReg;
    unique case (state)
      IDLE: begin
        if (Start) begin
          srcNext  = SrcAddr;
          dstNext  = DstAddr;
          remNext  = WordCount;
          fillNext = FillMode;
          if (FillMode) dataNext = FillValue;
          if (WordCount == '0) nextState = DONE;
          else if (FillMode)   nextState = WRITE;
          else                 nextState = READ;
        end
      end
      READ: begin
        waitNext  = WAIT_LOAD;
        nextState = WAIT;
      end
      WAIT: begin
        if (waitCnt == 2'd0) begin
          dataNext  = BusReadData;
          nextState = WRITE;
        end else begin
          waitNext = waitCnt - 2'd1;
        end
      end
      WRITE: begin
        // Pointers wrap naturally at 2^ADDR_W.
        srcNext = srcPtr + 1'b1;
        dstNext = dstPtr + 1'b1;
        remNext = remaining - 1'b1;
        if (remaining == REM_ONE) nextState = DONE;
        else if (fillMode)        nextState = WRITE;
        else                      nextState = READ;
      end
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CoreClock) begin
    if (Reset) begin
      state     <= IDLE;
      srcPtr    <= '0;
      dstPtr    <= '0;
      remaining <= '0;
      waitCnt   <= '0;
      fillMode  <= 1'b0;
      dataReg   <= '0;
      addrReg   <= '0;
      busyReg   <= 1'b0;
      doneReg   <= 1'b0;
      writeReg  <= 1'b0;
    end else begin
      state     <= nextState;
      srcPtr    <= srcNext;
      dstPtr    <= dstNext;
      remaining <= remNext;
      waitCnt   <= waitNext;
      fillMode  <= fillNext;
      dataReg   <= dataNext;
      busyReg   <= (nextState != IDLE);
      doneReg   <= (nextState == DONE);
      writeReg  <= (nextState == WRITE);
      // Address holds its last value outside READ/WRITE.
      if (nextState == READ)       addrReg <= srcNext;
      else if (nextState == WRITE) addrReg <= dstNext;
    end
  end

  assign Busy           = busyReg;
  assign Done           = doneReg;
  assign BusAddress     = addrReg;
  assign BusWriteData   = dataReg;
  assign BusWriteAssert = writeReg;

endmodule

// File: tb/tb_periph_bus_copy_engine.sv
// Bench for periph_bus_copy_engine: two instances (READ_LATENCY 1 and 3)
// share the command inputs, each with its own RAM model. Expected writes,
// timing and final memory image come from a word-by-word reference copy.
module tb_periph_bus_copy_engine;

  logic        CoreClock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        FillMode = 1'b0;
  logic [13:0] SrcAddr = '0;
  logic [13:0] DstAddr = '0;
  logic [14:0] WordCount = '0;
  logic [31:0] FillValue = '0;

  logic        busy  [2];
  logic        done  [2];
  logic [13:0] addr  [2];
  logic [31:0] wdata [2];
  logic        we    [2];
  logic [31:0] rdData[2];

  logic [31:0] mem    [2][16384];
  logic [31:0] rdPipe [2][4];
  logic [31:0] refMem [16384];
  logic        memInit = 1'b0;
  logic        pokeEn = 1'b0;
  logic [13:0] pokeAddr = '0;
  logic [31:0] pokeData = '0;

  int nChecks = 0;
  int nFail = 0;

  always #5 CoreClock = ~CoreClock;

  periph_bus_copy_engine #(.ADDR_W(14), .DATA_W(32), .READ_LATENCY(1)) dut (
    .CoreClock(CoreClock), .Reset(Reset), .Start(Start), .FillMode(FillMode),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .WordCount(WordCount), .FillValue(FillValue),
    .Busy(busy[0]), .Done(done[0]), .BusAddress(addr[0]), .BusWriteData(wdata[0]),
    .BusWriteAssert(we[0]), .BusReadData(rdData[0]));

  periph_bus_copy_engine #(.ADDR_W(14), .DATA_W(32), .READ_LATENCY(3)) dut3 (
    .CoreClock(CoreClock), .Reset(Reset), .Start(Start), .FillMode(FillMode),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .WordCount(WordCount), .FillValue(FillValue),
    .Busy(busy[1]), .Done(done[1]), .BusAddress(addr[1]), .BusWriteData(wdata[1]),
    .BusWriteAssert(we[1]), .BusReadData(rdData[1]));

  // Synchronous RAMs: read data appears N cycles after the address.
  always @(posedge CoreClock) begin
    if (memInit) begin
      for (int i = 0; i < 16384; i++) begin
        mem[0][i] <= $urandom;
        mem[1][i] <= $urandom;
      end
    end else if (pokeEn) begin
      mem[0][pokeAddr] <= pokeData;
      mem[1][pokeAddr] <= pokeData;
    end
    for (int s = 0; s < 2; s++) begin
      if (we[s]) mem[s][addr[s]] <= wdata[s];
      rdPipe[s][0] <= mem[s][addr[s]];
      for (int k = 1; k < 4; k++) rdPipe[s][k] <= rdPipe[s][k-1];
    end
  end
  assign rdData[0] = rdPipe[0][0];
  assign rdData[1] = rdPipe[1][2];

  task automatic poke(input logic [13:0] a, input logic [31:0] d);
    @(negedge CoreClock);
    pokeEn = 1'b1; pokeAddr = a; pokeData = d;
    @(negedge CoreClock);
    pokeEn = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    @(negedge CoreClock);
    while ((busy[0] || busy[1]) && c < 20000) begin
      @(negedge CoreClock);
      c++;
    end
    nChecks++;
    if (busy[0] || busy[1]) begin
      nFail++;
      $display("FAIL %s idle_timeout: busy=%0b/%0b required 0/0", tag, busy[0], busy[1]);
    end
  endtask

  task automatic randomize_inputs();
    SrcAddr   = 14'($urandom);
    DstAddr   = 14'($urandom);
    WordCount = 15'($urandom_range(1, 20));
    FillMode  = 1'($urandom);
    FillValue = $urandom;
  endtask

  // Issue one command, model it, watch instance sel, compare everything.
  task automatic do_cmd(input int sel, input logic fill, input logic [13:0] src,
                        input logic [13:0] dst, input logic [14:0] cnt,
                        input logic [31:0] fv, input bit spam, input string tag);
    int rl, n, doneCyc, busyCnt, doneCnt, doneAt, shown, diffs;
    logic [13:0] a, b;
    logic [31:0] d;
    logic [13:0] eAddr[$]; logic [31:0] eData[$]; int eCyc[$];
    logic [13:0] oAddr[$]; logic [31:0] oData[$]; int oCyc[$];
    rl = (sel == 1) ? 3 : 1;
    wait_idle(tag);
    for (int i = 0; i < 16384; i++) refMem[i] = mem[sel][i];
    n = int'(cnt);
    for (int i = 0; i < n; i++) begin
      a = dst + 14'(i);
      b = src + 14'(i);
      d = fill ? fv : refMem[b];
      refMem[a] = d;
      eAddr.push_back(a);
      eData.push_back(d);
      eCyc.push_back(fill ? 1 + i : (i + 1) * (2 + rl));
    end
    doneCyc = (n == 0) ? 1 : eCyc[n-1] + 1;
    busyCnt = 0; doneCnt = 0; doneAt = -1;
    Start = 1'b1; FillMode = fill; SrcAddr = src; DstAddr = dst;
    WordCount = cnt; FillValue = fv;
    for (int c = 1; c <= doneCyc + 3; c++) begin
      @(negedge CoreClock);
      if (we[sel]) begin
        oAddr.push_back(addr[sel]); oData.push_back(wdata[sel]); oCyc.push_back(c);
      end
      if (done[sel]) begin doneCnt++; doneAt = c; end
      if (busy[sel]) busyCnt++;
      randomize_inputs();
      Start = spam && (c <= doneCyc);
    end
    Start = 1'b0;
    nChecks++;
    if (oAddr.size() !== eAddr.size()) begin
      nFail++;
      $display("FAIL %s write_count: got %0d expected %0d", tag, oAddr.size(), eAddr.size());
    end
    shown = 0;
    for (int i = 0; i < n && i < oAddr.size(); i++) begin
      nChecks++;
      if (oAddr[i] !== eAddr[i] || oData[i] !== eData[i] || oCyc[i] !== eCyc[i]) begin
        nFail++;
        if (shown < 5)
          $display("FAIL %s write[%0d]: got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                   tag, i, oAddr[i], oData[i], oCyc[i], eAddr[i], eData[i], eCyc[i]);
        shown++;
      end
    end
    nChecks++;
    if (doneCnt !== 1 || doneAt !== doneCyc) begin
      nFail++;
      $display("FAIL %s done: got %0d pulses last at %0d expected 1 at %0d", tag, doneCnt, doneAt, doneCyc);
    end
    nChecks++;
    if (busyCnt !== doneCyc) begin
      nFail++;
      $display("FAIL %s busy_len: got %0d expected %0d", tag, busyCnt, doneCyc);
    end
    diffs = 0;
    for (int i = 0; i < 16384; i++) if (mem[sel][i] !== refMem[i]) diffs++;
    nChecks++;
    if (diffs !== 0) begin
      nFail++;
      $display("FAIL %s mem_image: got %0d differing words expected 0", tag, diffs);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Start = 1'b1;
    randomize_inputs();
    repeat (3) @(negedge CoreClock);
    for (int s = 0; s < 2; s++) begin
      nChecks++;
      if (busy[s] !== 1'b0 || done[s] !== 1'b0 || we[s] !== 1'b0 ||
          addr[s] !== 14'h0 || wdata[s] !== 32'h0) begin
        nFail++;
        $display("FAIL reset_state[%0d]: got busy=%b done=%b we=%b addr=%h wd=%h expected all 0",
                 s, busy[s], done[s], we[s], addr[s], wdata[s]);
      end
    end
    Start = 1'b0;
    Reset = 1'b0;
  endtask

  task automatic test_copy_basic();
    for (int i = 0; i < 4; i++) poke(14'h10 + 14'(i), 32'hA0 + 32'(i));
    do_cmd(0, 1'b0, 14'h0010, 14'h0100, 15'd4, 32'h0, 1'b0, "copy_basic");
  endtask

  task automatic test_fill_basic();
    do_cmd(0, 1'b1, 14'h3000, 14'h0200, 15'd3, 32'hDEADBEEF, 1'b0, "fill_basic");
  endtask

  task automatic test_zero_count();
    do_cmd(0, 1'b0, 14'h0055, 14'h0066, 15'd0, 32'h0, 1'b0, "zero_copy");
    do_cmd(0, 1'b1, 14'h0055, 14'h0066, 15'd0, 32'h1234, 1'b0, "zero_fill");
  endtask

  task automatic test_wrap();
    do_cmd(0, 1'b0, 14'h3FFE, 14'h3FFF, 15'd3, 32'h0, 1'b0, "wrap_copy");
    do_cmd(0, 1'b1, 14'h0, 14'h3FFD, 15'd5, 32'hCAFEF00D, 1'b0, "wrap_fill");
  endtask

  task automatic test_overlap();
    do_cmd(0, 1'b0, 14'h0020, 14'h0021, 15'd5, 32'h0, 1'b0, "overlap_fwd");
    do_cmd(0, 1'b0, 14'h0031, 14'h0030, 15'd5, 32'h0, 1'b0, "overlap_back");
  endtask

  task automatic test_reset_mid();
    int wBefore, bad;
    wait_idle("reset_mid");
    Start = 1'b1; FillMode = 1'b0; SrcAddr = 14'h0040; DstAddr = 14'h0080; WordCount = 15'd4;
    wBefore = 0; bad = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CoreClock);
      Start = 1'b0;
      if (c <= 5 && we[0]) wBefore++;
      if (c == 6) begin
        nChecks++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0 || we[0] !== 1'b0 || addr[0] !== 14'h0) begin
          nFail++;
          $display("FAIL reset_mid_state: got busy=%b done=%b we=%b addr=%h expected 0/0/0/0",
                   busy[0], done[0], we[0], addr[0]);
        end
      end
      if (c >= 6 && (we[0] || done[0] || busy[0])) bad++;
      Reset = (c == 5);
    end
    nChecks++;
    if (wBefore !== 1) begin
      nFail++;
      $display("FAIL reset_mid_prewrites: got %0d expected 1", wBefore);
    end
    nChecks++;
    if (bad !== 0) begin
      nFail++;
      $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", bad);
    end
    do_cmd(0, 1'b0, 14'h0040, 14'h0090, 15'd2, 32'h0, 1'b0, "after_reset");
  endtask

  task automatic test_ignore_start();
    do_cmd(0, 1'b0, 14'h0500, 14'h0600, 15'd3, 32'h0, 1'b1, "ignore_copy");
    do_cmd(0, 1'b1, 14'h0500, 14'h0700, 15'd4, 32'h5A5A5A5A, 1'b1, "ignore_fill");
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++)
      do_cmd(0, 1'($urandom), 14'($urandom), 14'($urandom), 15'($urandom_range(1, 8)),
             $urandom, 1'($urandom), "random");
  endtask

  task automatic test_full_fill();
    do_cmd(0, 1'b1, 14'h0, 14'h1234, 15'h4000, 32'h0F0F1234, 1'b0, "full_fill");
  endtask

  task automatic test_latency3();
    do_cmd(1, 1'b0, 14'h0123, 14'h0456, 15'd3, 32'h0, 1'b0, "lat3_copy");
    do_cmd(1, 1'b0, 14'h3FFF, 14'h0010, 15'd2, 32'h0, 1'b1, "lat3_wrap");
  endtask

  initial begin
    memInit = 1'b1;
    @(negedge CoreClock);
    memInit = 1'b0;
    test_reset();
    test_copy_basic();
    test_fill_basic();
    test_zero_count();
    test_wrap();
    test_overlap();
    test_reset_mid();
    test_ignore_start();
    test_random();
    test_full_fill();
    test_latency3();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
